// File: rtl/reg_piso.sv
// reg_piso: parallel-in / serial-out register with load/ready handshake.
// A captured word is emitted one bit per cycle on q (MSB or LSB first),
// with q_valid marking frame bits and done pulsing on the final bit.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after the data bits.
// All outputs come straight from flops; reset is synchronous, active-high.

module reg_piso #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

    localparam int             CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    // Bit presented first from a word, honouring the shift order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word after moving the next bit into the output position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

`ifdef PISO_PARITY_EN
    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    state_t             state_r, state_n_s;
    logic [WIDTH-1:0]   shift_r, shift_n_s;
    logic [CNT_W-1:0]   cnt_r,   cnt_n_s;
    logic               q_r,     q_n_s;
    logic               q_valid_r, q_valid_n_s;
    logic               done_r,  done_n_s;
    logic               ready_r, ready_n_s;
    logic               accept_s;
`ifdef PISO_PARITY_EN
    logic               par_r,   par_n_s;
`endif

    // A word is taken only when the block advertises ready in this cycle.
    assign accept_s = load && ready_r;

    // Next-state and next-output logic; outputs describe the upcoming cycle.
    always_comb begin
        state_n_s   = state_r;
        shift_n_s   = shift_r;
        cnt_n_s     = cnt_r;
        q_n_s       = 1'b0;
        q_valid_n_s = 1'b0;
        done_n_s    = 1'b0;
        ready_n_s   = 1'b1;
`ifdef PISO_PARITY_EN
        par_n_s     = par_r;
`endif
        if (accept_s) begin
            // Start a frame: first bit appears in the cycle after the accept.
            state_n_s   = SHIFT;
            shift_n_s   = d_in;
            cnt_n_s     = {CNT_W{1'b0}};
            q_n_s       = first_bit(d_in);
            q_valid_n_s = 1'b1;
            ready_n_s   = 1'b0;
`ifdef PISO_PARITY_EN
            par_n_s     = even_parity(d_in);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_n_s = IDLE;
                end
                SHIFT: begin
                    if (cnt_r != CNT_LAST) begin
                        state_n_s   = SHIFT;
                        cnt_n_s     = cnt_r + CNT_ONE;
                        shift_n_s   = advance(shift_r);
                        q_n_s       = first_bit(advance(shift_r));
                        q_valid_n_s = 1'b1;
`ifdef PISO_PARITY_EN
                        done_n_s    = 1'b0;
                        ready_n_s   = 1'b0;
`else
                        // The upcoming bit is the last one: flag it and reopen.
                        if (cnt_r == CNT_PENULT) begin
                            done_n_s  = 1'b1;
                            ready_n_s = 1'b1;
                        end else begin
                            done_n_s  = 1'b0;
                            ready_n_s = 1'b0;
                        end
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state_n_s   = PARITY;
                        q_n_s       = par_r;
                        q_valid_n_s = 1'b1;
                        done_n_s    = 1'b1;
                        ready_n_s   = 1'b1;
`else
                        state_n_s   = IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_n_s = IDLE;
                end
`endif
                default: begin
                    state_n_s = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            shift_r   <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            q_r       <= 1'b0;
            q_valid_r <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
`ifdef PISO_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_n_s;
            shift_r   <= shift_n_s;
            cnt_r     <= cnt_n_s;
            q_r       <= q_n_s;
            q_valid_r <= q_valid_n_s;
            done_r    <= done_n_s;
            ready_r   <= ready_n_s;
`ifdef PISO_PARITY_EN
            par_r     <= par_n_s;
`endif
        end
    end

    assign ready   = ready_r;
    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign done    = done_r;

endmodule

// File: tb/tb_reg_piso.sv
// Self-checking bench for reg_piso: two instances (MSB-first and LSB-first)
// share stimulus; a queue-of-pending-bits model predicts every output each
// cycle, and literal frame captures pin the model's results.

module tb_reg_piso;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] d_in;
    logic       load;
    logic       ready_m, q_m, q_valid_m, done_m;
    logic       ready_l, q_l, q_valid_l, done_l;

    int n_checks;
    int n_pass;

    // Pending frame bits, oldest first, for each shift order.
    bit mq_m[$];
    bit mq_l[$];

    logic [31:0] cap_m, cap_l;
    int          n_qv, n_done;

    reg_piso #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .d_in(d_in), .load(load),
        .ready(ready_m), .q(q_m), .q_valid(q_valid_m), .done(done_m)
    );

    reg_piso #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .d_in(d_in), .load(load),
        .ready(ready_l), .q(q_l), .q_valid(q_valid_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input logic ld, input logic [7:0] d, input logic rst);
        bit acc;
        load  = ld;
        d_in  = d;
        reset = rst;
        @(posedge clk);
        if (rst) begin
            mq_m.delete();
            mq_l.delete();
        end else begin
            acc = ld && (mq_m.size() <= 1);
            if (mq_m.size() > 0) void'(mq_m.pop_front());
            if (mq_l.size() > 0) void'(mq_l.pop_front());
            if (acc) begin
                for (int i = 7; i >= 0; i--) mq_m.push_back(d[i]);
                for (int i = 0; i < 8; i++)  mq_l.push_back(d[i]);
`ifdef PISO_PARITY_EN
                mq_m.push_back(^d);
                mq_l.push_back(^d);
`endif
            end
        end
        @(negedge clk);
        chk("m_q_valid", q_valid_m, (mq_m.size() > 0) ? 1 : 0);
        chk("m_q",       q_m,       (mq_m.size() > 0) ? mq_m[0] : 0);
        chk("m_done",    done_m,    (mq_m.size() == 1) ? 1 : 0);
        chk("m_ready",   ready_m,   (mq_m.size() <= 1) ? 1 : 0);
        chk("l_q_valid", q_valid_l, (mq_l.size() > 0) ? 1 : 0);
        chk("l_q",       q_l,       (mq_l.size() > 0) ? mq_l[0] : 0);
        chk("l_done",    done_l,    (mq_l.size() == 1) ? 1 : 0);
        chk("l_ready",   ready_l,   (mq_l.size() <= 1) ? 1 : 0);
        if (q_valid_m) begin
            cap_m = {cap_m[30:0], q_m};
            n_qv++;
        end
        if (q_valid_l) cap_l = {cap_l[30:0], q_l};
        if (done_m) n_done++;
    endtask

    task automatic clear_cap();
        cap_m  = 32'd0;
        cap_l  = 32'd0;
        n_qv   = 0;
        n_done = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        load  = 1'b0;
        d_in  = 8'h00;
        reset = 1'b1;
        clear_cap();

        // Reset, with a load on the same edge that must be ignored.
        @(posedge clk);
        step(1'b1, 8'h99, 1'b1);
        chk("rst_ready",   ready_m,   32'd1);
        chk("rst_q_valid", q_valid_m, 32'd0);
        chk("rst_done",    done_m,    32'd0);
        idle(1);
        chk("rst_no_accept", q_valid_m, 32'd0);

        // Single word 8'h01 in both shift orders.
        clear_cap();
        step(1'b1, 8'h01, 1'b0);
        idle(FRAME);
`ifdef PISO_PARITY_EN
        chk("h01_msb", cap_m, 32'b000000011);
        chk("h01_lsb", cap_l, 32'b100000001);
`else
        chk("h01_msb", cap_m, 32'h01);
        chk("h01_lsb", cap_l, 32'h80);
`endif
        chk("h01_qv_cycles", n_qv, FRAME);
        chk("h01_done_cnt",  n_done, 32'd1);

        // Back-to-back: 8'hFF, then 8'h00 accepted on the final-bit cycle.
        clear_cap();
        step(1'b1, 8'hFF, 1'b0);
        idle(FRAME - 1);
        step(1'b1, 8'h00, 1'b0);
        idle(FRAME);
`ifdef PISO_PARITY_EN
        chk("b2b_bits", cap_m, 32'b111111110000000000);
`else
        chk("b2b_bits", cap_m, 32'hFF00);
`endif
        chk("b2b_qv_cycles", n_qv, 2 * FRAME);
        chk("b2b_done_cnt",  n_done, 32'd2);

        // Loads while busy are dropped: 8'h55 must never appear.
        clear_cap();
        step(1'b1, 8'hAA, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 1'b0);
        idle(FRAME);
`ifdef PISO_PARITY_EN
        chk("busy_ignore", cap_m, 32'b101010100);
`else
        chk("busy_ignore", cap_m, 32'hAA);
`endif
        chk("busy_done_cnt", n_done, 32'd1);

        // Mid-frame reset aborts the frame with no done pulse.
        clear_cap();
        step(1'b1, 8'hF0, 1'b0);
        idle(3);
        step(1'b1, 8'h0F, 1'b1);
        chk("abort_ready", ready_m,   32'd1);
        chk("abort_qv",    q_valid_m, 32'd0);
        idle(FRAME);
        chk("abort_bits",     cap_m,  32'hF);
        chk("abort_qv_cycles", n_qv,  32'd4);
        chk("abort_done_cnt", n_done, 32'd0);

        // Assorted word, checked by the per-cycle model only.
        step(1'b1, 8'h3C, 1'b0);
        idle(FRAME + 1);

`ifdef PISO_PARITY_EN
        // Parity bit values on two words.
        clear_cap();
        step(1'b1, 8'h07, 1'b0);
        idle(FRAME);
        chk("par_h07", cap_m[0], 32'd1);
        clear_cap();
        step(1'b1, 8'h03, 1'b0);
        idle(FRAME);
        chk("par_h03", cap_m[0], 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
